// File: rtl/decode_redirect_pkg.sv
// dlx_decode_pkg: opcodes, NOP encoding, redirect types and
// trap states shared by the decode-side redirect logic.
package dlx_decode_pkg;

    localparam logic [0:5] OP_NOP  = 6'h00;
    localparam logic [0:5] OP_J    = 6'h02;
    localparam logic [0:5] OP_JAL  = 6'h03;
    localparam logic [0:5] OP_BEQZ = 6'h04;
    localparam logic [0:5] OP_BNEZ = 6'h05;
    localparam logic [0:5] OP_BFPT = 6'h06;
    localparam logic [0:5] OP_BFPF = 6'h07;
    localparam logic [0:5] OP_RFE  = 6'h10;
    localparam logic [0:5] OP_TRAP = 6'h11;
    localparam logic [0:5] OP_JR   = 6'h12;
    localparam logic [0:5] OP_JALR = 6'h13;

    localparam logic [0:5] FN_NOP  = 6'h15;

    typedef enum logic [1:0] {
        JT_SEQ   = 2'b00,
        JT_PCREL = 2'b01,
        JT_REG   = 2'b10,
        JT_IAR   = 2'b11
    } jump_t;

    typedef enum logic [1:0] {
        TS_IDLE   = 2'b00,
        TS_DRAIN  = 2'b01,
        TS_VECTOR = 2'b10
    } trap_state_t;

    typedef struct packed {
        logic [0:5]  op;
        logic [0:5]  fn;
        logic [0:31] pc4;
        logic [0:4]  rs1;
        logic [0:4]  rs2;
        logic [0:4]  rd;
        logic [0:15] imm;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_NOP = '{
        op:    OP_NOP,
        fn:    FN_NOP,
        pc4:   32'h0,
        rs1:   5'h0,
        rs2:   5'h0,
        rd:    5'h0,
        imm:   16'h0,
        valid: 1'b0
    };

    // Loads occupy 0x20..0x27 (top three bits 100).
    function automatic logic is_load(input logic [0:5] op);
        return op[0:2] == 3'b100;
    endfunction

    // LF/LD (0x26, 0x27) target the FP register file.
    function automatic logic is_fp_load(input logic [0:5] op);
        return op[0:4] == 5'b10011;
    endfunction

endpackage

// File: rtl/decode_redirect_if.sv
// decode_redirect_if: fetch/decode bus. Fetch (master) drives
// the instruction fields, Decode (slave) drives the redirects.
interface decode_redirect_if;

    logic [0:5]  OpCode;
    logic [0:5]  Function;
    logic [0:31] PCPlusFour;
    logic [0:4]  Rs1;
    logic [0:4]  Rs2;
    logic [0:4]  Rd;
    logic [0:15] Immediate;

    logic [0:1]  JumpType;
    logic        BranchCond;
    logic        CondSrc;
    logic        BranchResult;
    logic [0:31] JumpReg;
    logic [0:31] IAR;
    logic [0:5]  DecodeRd;
    logic [0:31] DecodePCPlusFour;

    modport master (
        output OpCode, Function, PCPlusFour,
        output Rs1, Rs2, Rd, Immediate,
        input  JumpType, BranchCond, CondSrc,
        input  BranchResult, JumpReg, IAR,
        input  DecodeRd, DecodePCPlusFour
    );

    modport slave (
        input  OpCode, Function, PCPlusFour,
        input  Rs1, Rs2, Rd, Immediate,
        output JumpType, BranchCond, CondSrc,
        output BranchResult, JumpReg, IAR,
        output DecodeRd, DecodePCPlusFour
    );

endinterface

// File: rtl/decode_redirect_trap_ctrl.sv
// decode_trap_ctrl: TRAP sequencing. Saves IAR, drains the
// pipe for DrainCycles, then emits the trap vector once.
module decode_trap_ctrl
    import dlx_decode_pkg::*;
#(
    parameter logic [31:0] TrapBase    = 32'h0000_0100,
    parameter int          DrainCycles = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        trap_req,
    input  logic [0:15] trap_imm,
    input  logic [0:31] ret_addr,
    output logic        hold,
    output logic        vec_active,
    output logic [0:31] vec_target,
    output logic [0:31] iar
);

    localparam logic [2:0] DrainLoad = 3'(DrainCycles - 1);

    trap_state_t state;
    trap_state_t state_nx;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nx;
    logic [0:15] imm_q;
    logic [0:15] imm_nx;
    logic [0:31] iar_nx;
    logic        fire;

    // State, counter, vector index and IAR; stall freezes all.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= TS_IDLE;
            cnt   <= 3'd0;
            imm_q <= 16'h0;
            iar   <= 32'h0;
        end else if (!stall) begin
            state <= state_nx;
            cnt   <= cnt_nx;
            imm_q <= imm_nx;
            iar   <= iar_nx;
        end
    end

    // Next-state: trigger from IDLE, count down, vector once.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        imm_nx   = imm_q;
        iar_nx   = iar;
        fire     = 1'b0;
        unique case (state)
            TS_IDLE: begin
                if (trap_req) begin
                    fire     = 1'b1;
                    state_nx = TS_DRAIN;
                    cnt_nx   = DrainLoad;
                    imm_nx   = trap_imm;
                    iar_nx   = ret_addr;
                end
            end
            TS_DRAIN: begin
                if (cnt == 3'd0) begin
                    state_nx = TS_VECTOR;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            TS_VECTOR: state_nx = TS_IDLE;
            default:   state_nx = TS_IDLE;
        endcase
    end

    assign hold       = (state != TS_IDLE) || fire;
    assign vec_active = (state == TS_VECTOR);
    assign vec_target = TrapBase + ({16'h0, imm_q} << 2);

endmodule

// File: rtl/decode_redirect.sv
// decode_redirect: IF/ID register and redirect decode for Fetch.
// Define DECODE_TRAP_EN to build in TRAP/RFE and the IAR.
module decode_redirect
    import dlx_decode_pkg::*;
#(
    parameter logic [31:0] TrapBase    = 32'h0000_0100,
    parameter int          DrainCycles = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [0:31] RegA,
    decode_redirect_if.slave fe,
    output logic [0:5]  DOpCode,
    output logic [0:5]  DFunction,
    output logic [0:4]  DRs1,
    output logic [0:4]  DRs2,
    output logic [0:4]  DRd,
    output logic [0:15] DImmediate,
    output logic        DValid
);

    if (DrainCycles < 1 || DrainCycles > 7
        || TrapBase[1:0] != 2'b00) begin : g_cfg_bad
        $error("decode_redirect: bad DrainCycles/TrapBase");
    end

    if_id_t      ifid;
    jump_t       dec_jt;
    jump_t       jt;
    logic        br_cond;
    logic        cond_src;
    logic        jreg_sel;
    logic        squash;
    logic        trap_hold;
    logic        vec_active;
    logic [0:31] vec_target;
    logic [0:31] iar;
    logic [0:31] jump_reg;

    // IF/ID register: NOP on squash or while a trap is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid <= IF_ID_NOP;
        end else if (!stall) begin
            if (squash || trap_hold) begin
                ifid <= IF_ID_NOP;
            end else begin
                ifid <= '{
                    op:    fe.OpCode,
                    fn:    fe.Function,
                    pc4:   fe.PCPlusFour,
                    rs1:   fe.Rs1,
                    rs2:   fe.Rs2,
                    rd:    fe.Rd,
                    imm:   fe.Immediate,
                    valid: 1'b1
                };
            end
        end
    end

    // Classify the latched instruction; invalid slots never redirect.
    always_comb begin
        dec_jt   = JT_SEQ;
        br_cond  = 1'b0;
        cond_src = 1'b0;
        jreg_sel = 1'b0;
        if (ifid.valid) begin
            unique case (1'b1)
                (ifid.op == OP_J) || (ifid.op == OP_JAL): begin
                    dec_jt = JT_PCREL;
                end
                (ifid.op == OP_BEQZ): begin
                    dec_jt  = JT_PCREL;
                    br_cond = 1'b1;
                end
                (ifid.op == OP_BNEZ): begin
                    dec_jt = JT_PCREL;
                end
                (ifid.op == OP_BFPT): begin
                    dec_jt   = JT_PCREL;
                    br_cond  = 1'b1;
                    cond_src = 1'b1;
                end
                (ifid.op == OP_BFPF): begin
                    dec_jt   = JT_PCREL;
                    cond_src = 1'b1;
                end
                (ifid.op == OP_JR) || (ifid.op == OP_JALR): begin
                    dec_jt   = JT_REG;
                    jreg_sel = 1'b1;
                end
`ifdef DECODE_TRAP_EN
                (ifid.op == OP_RFE): begin
                    dec_jt = JT_IAR;
                end
`endif
                default: ;
            endcase
        end
    end

    // Trap vector overrides the decoded redirect.
    always_comb begin
        jt       = dec_jt;
        jump_reg = jreg_sel ? RegA : 32'h0;
        if (vec_active) begin
            jt       = JT_REG;
            jump_reg = vec_target;
        end
    end

    // Kill the one wrong-path fetch behind any taken redirect.
    assign squash = !stall
        && ((ifid.valid && dec_jt != JT_SEQ) || vec_active);

`ifdef DECODE_TRAP_EN
    decode_trap_ctrl #(
        .TrapBase    (TrapBase),
        .DrainCycles (DrainCycles)
    ) u_trap (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .trap_req   (ifid.valid && ifid.op == OP_TRAP),
        .trap_imm   (ifid.imm),
        .ret_addr   (ifid.pc4),
        .hold       (trap_hold),
        .vec_active (vec_active),
        .vec_target (vec_target),
        .iar        (iar)
    );
`else
    assign trap_hold  = 1'b0;
    assign vec_active = 1'b0;
    assign vec_target = 32'h0;
    assign iar        = 32'h0;
`endif

    assign fe.JumpType         = jt;
    assign fe.BranchCond       = br_cond;
    assign fe.CondSrc          = cond_src;
    assign fe.BranchResult     = (RegA == 32'h0);
    assign fe.JumpReg          = jump_reg;
    assign fe.IAR              = iar;
    assign fe.DecodePCPlusFour = ifid.pc4;
    assign fe.DecodeRd         = (ifid.valid && is_load(ifid.op))
        ? {is_fp_load(ifid.op), ifid.rd} : 6'h00;

    assign DOpCode    = ifid.op;
    assign DFunction  = ifid.fn;
    assign DRs1       = ifid.rs1;
    assign DRs2       = ifid.rs2;
    assign DRd        = ifid.rd;
    assign DImmediate = ifid.imm;
    assign DValid     = ifid.valid;

endmodule

// File: doc/decode_redirect.md
# decode_redirect

Decode-side end of the fetch/decode interface. Holds the IF/ID pipeline register and classifies the latched instruction into the redirect controls that Fetch consumes. Those controls are JumpType, BranchCond, CondSrc, BranchResult, JumpReg, IAR, DecodeRd and DecodePCPlusFour. The block also sequences TRAP/RFE: it saves IAR, drains the pipeline and then vectors Fetch to the trap handler.

## Interface

Parameters:
- TrapBase, 32'h0000_0100, base address of the trap vector table.
- DrainCycles, 3, number of cycles of NOP issue before the trap vector is emitted (legal range 1..7).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- stall  in  1  holds the IF/ID register, the squash flag and the trap FSM.
- OpCode, Function  in  [0:5]  from Fetch.
- PCPlusFour  in  [0:31]  from Fetch.
- Rs1, Rs2, Rd  in  [0:4]  from Fetch.
- Immediate  in  [0:15]  from Fetch.
- RegA  in  [0:31]  async register-file read of the latched Rs1.
- JumpType  out  [0:1]  redirect type: 00 sequential, 01 PC-relative, 10 JumpReg, 11 IAR.
- BranchCond  out  1  1 for BEQZ/BFPT, 0 for BNEZ/BFPF.
- CondSrc  out  1  0 selects the GPR test, 1 selects FPSR.
- BranchResult  out  1  (RegA == 0).
- JumpReg  out  [0:31]  register-jump or trap-vector target.
- IAR  out  [0:31]  saved return address.
- DecodeRd  out  [0:5]  load destination {fp, Rd}; 6'h00 when the latched instruction is not a load.
- DecodePCPlusFour  out  [0:31]  latched PCPlusFour.
- DOpCode, DFunction  out  [0:5]  latched fields to Execute.
- DRs1, DRs2, DRd  out  [0:4]  latched fields to Execute.
- DImmediate  out  [0:15]  latched field to Execute.
- DValid  out  1  latched instruction is not a squash or trap NOP.

## Operation

- IF/ID register: loads the Fetch outputs each cycle when stall=0.
- The register instead loads NOP (opcode 6'h00, function 6'h15, other fields 0, DValid=0) in either of these cases:
  - squash flag is set;
  - trap FSM is not IDLE.
- Decode of the latched instruction (combinational):
  - J 0x02, JAL 0x03: JumpType 01.
  - BEQZ 0x04, BNEZ 0x05: JumpType 01, CondSrc 0.
  - BFPT 0x06, BFPF 0x07: JumpType 01, CondSrc 1.
  - JR 0x12, JALR 0x13: JumpType 10, JumpReg = RegA.
  - RFE 0x10: JumpType 11.
  - All other opcodes: JumpType 00.
- Loads 0x20–0x27: DecodeRd = {op∈{0x26,0x27}, DRd}.
- Squash flag:
  - Set for one cycle after any non-stalled cycle with JumpType≠00 and DValid=1. This kills the single wrong-path instruction.
  - For conditional branches the flag is set regardless of the branch outcome; Fetch re-fetches the fall-through instruction.
- Trap FSM (states IDLE, DRAIN, VECTOR):
  - IDLE → DRAIN: latched TRAP 0x11 with DValid=1 and stall=0. On this transition IAR ← DecodePCPlusFour, the FSM captures Immediate, and the drain counter loads DrainCycles−1.
  - DRAIN: JumpType 00. The counter decrements on each non-stalled cycle. At 0 the FSM goes to VECTOR.
  - VECTOR, for one non-stalled cycle: JumpType 10, JumpReg = TrapBase + ({16'h0, imm} << 2), computed modulo 2^32. Then the FSM returns to IDLE and the squash flag is set.
  - While the FSM is not IDLE, the latched TRAP does not re-trigger.
- Stall freezes all state. Redirect outputs remain driven from the held contents.

## Timing

- Reset (synchronous) drives:
  - every output to 0, except DFunction = 6'h15;
  - IF/ID contents to NOP; DValid = 0;
  - IAR = 0; squash = 0; FSM = IDLE.
- Fetch-to-decode latency is 1 cycle. Redirect outputs are valid in the same cycle the instruction is latched.
- TRAP latched in cycle t: DRAIN covers cycles t+1 .. t+DrainCycles. The vector is emitted at t+DrainCycles+1, assuming no stall.
- Reset asserted mid-trap: the FSM returns to IDLE and IAR is cleared; the vector is never emitted.
- stall=1 during VECTOR: the vector stays asserted until the first non-stalled cycle.
- RFE latched with DValid=0: no redirect.

## Configuration

- Macro DECODE_TRAP_EN, when defined: the trap FSM, the IAR register and the RFE decode are compiled in.
- When undefined:
  - TRAP and RFE decode as JumpType 00;
  - IAR is tied to 0;
  - no drain cycles are inserted.

## Structure

- Package dlx_decode_pkg holds:
  - opcode constants;
  - the NOP encoding;
  - the JumpType encodings (JT_SEQ, JT_PCREL, JT_REG, JT_IAR);
  - the trap state enum.
- Sub-module decode_trap_ctrl contains the FSM, the drain counter, the IAR register and the vector adder. It is instantiated only under DECODE_TRAP_EN.

## Test plan

- Reset, then release: all outputs 0, DFunction 6'h15, DValid 0.
- BEQZ with RegA=0: JumpType 01, CondSrc 0, BranchCond 1, BranchResult 1. The next cycle latches NOP with DValid 0.
- JR with RegA=32'h0000_2000: JumpType 10, JumpReg 32'h0000_2000. Hold stall=1 for 2 cycles: outputs remain unchanged and the squash flag is not set until the stall releases.
- LW (0x23) with Rd=5 followed by LD (0x27) with Rd=3: DecodeRd 6'h05, then 6'h23.
- TRAP with imm 4 at PCPlusFour 32'h40:
  - IAR becomes 32'h40;
  - 3 cycles of JumpType 00 with NOP;
  - then JumpType 10 with JumpReg 32'h0000_0110;
  - then RFE produces JumpType 11.
- TRAP followed by reset in the 2nd DRAIN cycle: IAR 0, FSM IDLE, no vector emitted.
